// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared debouncer state encoding and default stability length
package button_debouncer_pkg;
  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;
  localparam int STABLE_CYCLES_DEF = 4;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser plus stability FSM producing a clean level and edge pulses
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s1, s2, out_n, rise_n, fall_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  state_t state, state_n;
  always_ff @(posedge clk) begin
    if (clr) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
      state <= LOW;
    end else begin
      s1    <= raw;
      s2    <= s1;
      out   <= out_n;
      rise  <= rise_n;
      fall  <= fall_n;
      cnt   <= cnt_n;
      state <= state_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    out_n   = out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (state == LOW || state == HIGH) begin
      if (s2 != (state == HIGH)) begin
        state_n = (state == HIGH) ? FALLING : RISING;
        cnt_n   = CNT_W'(1);
      end
    end else if (s2 != (state == RISING)) begin
      state_n = (state == RISING) ? LOW : HIGH;
    end else if (cnt == LAST) begin
      state_n = (state == RISING) ? HIGH : LOW;
      out_n   = (state == RISING);
      rise_n  = (state == RISING);
      fall_n  = (state == FALLING);
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: two independent debounced button channels with rise/fall pulses
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);
  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_a (
    .clk (clk),
    .clr (clr),
    .raw (btn_a_raw),
    .out (a),
    .rise(a_rise),
    .fall(a_fall)
  );
  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_b (
    .clk (clk),
    .clr (clr),
    .raw (btn_b_raw),
    .out (b),
    .rise(b_rise),
    .fall(b_fall)
  );
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: randomized scoreboard bench against a sample-history reference model
module tb_button_debouncer;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic btn_a_raw = 1'b0;
  logic btn_b_raw = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall;
  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q[$];
  logic [SC+1:0] ha = '0;
  logic [SC+1:0] hb = '0;
  logic ma = 1'b0;
  logic mb = 1'b0;
  logic [2:0] ra, rb;
  button_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_a_raw(btn_a_raw),
    .btn_b_raw(btn_b_raw),
    .a        (a),
    .b        (b),
    .a_rise   (a_rise),
    .a_fall   (a_fall),
    .b_rise   (b_rise),
    .b_fall   (b_fall)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] step(input logic [SC+1:0] h, input logic o);
    logic [SC-1:0] w;
    logic no;
    w  = h[SC+1:2];
    no = (&w) ? 1'b1 : (~|w) ? 1'b0 : o;
    return {no, no & ~o, ~no & o};
  endfunction
  always @(posedge clk) begin
    if (clr) begin
      ha = '0;
      hb = '0;
      ma = 1'b0;
      mb = 1'b0;
      exp_q.push_back(6'b0);
    end else begin
      ha = {ha[SC:0], btn_a_raw};
      hb = {hb[SC:0], btn_b_raw};
      ra = step(ha, ma);
      rb = step(hb, mb);
      ma = ra[2];
      mb = rb[2];
      exp_q.push_back({ra, rb});
    end
  end
  always @(posedge clk) begin
    logic [5:0] got, exp_v;
    #1;
    got = {a, a_rise, a_fall, b, b_rise, b_fall};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty t=%0t got=%b expected an entry", $time, got);
    end else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        fails++;
        $display("FAIL outputs t=%0t got {a,ar,af,b,br,bf}=%b expected=%b", $time, got, exp_v);
      end
    end
  end
  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask
  task automatic drive(input logic va, input logic vb, input int n);
    btn_a_raw = va;
    btn_b_raw = vb;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int n;
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_a_low", int'(a), 0);
    check("reset_b_low", int'(b), 0);
    clr = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (a_rise) begin
        n = i;
        break;
      end
    end
    check("release_rise_edge", n, 6);
    check("release_b_same_edge", int'(b_rise), 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 8);
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 3);
    clr = 1'b1;
    drive(1'b1, 1'b0, 1);
    clr = 1'b0;
    drive(1'b1, 1'b0, 10);
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
    end
    clr = 1'b0;
    drive(1'b0, 1'b0, 10);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
